// File: rtl/conv_data_seq_pkg.sv
// Shared widths and FSM encodings for the controller-to-PE data-run sequencer.
package conv_data_seq_pkg;

   localparam int unsigned SEQ_W_SIZE       = 8;
   localparam int unsigned SEQ_W_CHANNEL    = 6;
   localparam int unsigned SEQ_W_FRAME_SIZE = 16;
   localparam int unsigned SEQ_W_DELAY      = 8;
   localparam int unsigned IFM_BUFFER_CNT   = 4;
   localparam int unsigned IFM_BUFFER       = 2;

   typedef enum logic [2:0] {
      SEQ_IDLE     = 3'd0,
      SEQ_WAIT_ROW = 3'd1,
      SEQ_RUN      = 3'd2,
      SEQ_DRAIN    = 3'd3,
      SEQ_DONE     = 3'd4
   } seq_state_e;

endpackage

// File: rtl/conv_idx_counter.sv
// Nested channel/column/row wrap counter holding the next beat position to issue.
module conv_idx_counter #(
   parameter int unsigned W_SIZE    = 8,
   parameter int unsigned W_CHANNEL = 6
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_clr,
   input  logic                 i_en,
   input  logic [W_SIZE-1:0]    i_last_col,
   input  logic [W_SIZE-1:0]    i_last_row,
   input  logic [W_CHANNEL-1:0] i_last_chn,
   output logic [W_SIZE-1:0]    o_row,
   output logic [W_SIZE-1:0]    o_col,
   output logic [W_CHANNEL-1:0] o_chn,
   output logic                 o_chn_wrap_c,
   output logic                 o_col_wrap_c,
   output logic                 o_row_wrap_c
);

   logic [W_SIZE-1:0]    r_row;
   logic [W_SIZE-1:0]    r_col;
   logic [W_CHANNEL-1:0] r_chn;

   assign o_row        = r_row;
   assign o_col        = r_col;
   assign o_chn        = r_chn;
   assign o_chn_wrap_c = (r_chn == i_last_chn);
   assign o_col_wrap_c = (r_col == i_last_col);
   assign o_row_wrap_c = (r_row == i_last_row);

   // Advance channel innermost, then column, then row on each enabled beat.
   always_ff @(posedge clk) begin
      if (rstn || i_clr) begin
         r_row <= '0;
         r_col <= '0;
         r_chn <= '0;
      end else if (i_en) begin
         if (o_chn_wrap_c) begin
            r_chn <= '0;
            if (o_col_wrap_c) begin
               r_col <= '0;
               r_row <= r_row + W_SIZE'(1);
            end else begin
               r_col <= r_col + W_SIZE'(1);
            end
         end else begin
            r_chn <= r_chn + W_CHANNEL'(1);
         end
      end
   end

endmodule

// File: rtl/conv_data_seq.sv
// Frame sequencer issuing row/col/channel-tile data-run beats into the PE array.
module conv_data_seq
   import conv_data_seq_pkg::*;
#(
   parameter int unsigned W_SIZE       = SEQ_W_SIZE,
   parameter int unsigned W_CHANNEL    = SEQ_W_CHANNEL,
   parameter int unsigned W_FRAME_SIZE = SEQ_W_FRAME_SIZE,
   parameter int unsigned W_DELAY      = SEQ_W_DELAY,
   parameter int unsigned IFM_BUF_CNT  = IFM_BUFFER_CNT,
   parameter int unsigned W_IFM_BUF    = IFM_BUFFER
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_start,
   input  logic [W_SIZE-1:0]       q_width,
   input  logic [W_SIZE-1:0]       q_height,
   input  logic [W_CHANNEL-1:0]    q_channel,
   input  logic [W_DELAY-1:0]      q_drain,
   input  logic                    i_row_ready,
   input  logic                    i_stall,
   output logic                    c_ctrl_data_run,
   output logic [W_SIZE-1:0]       c_row,
   output logic [W_SIZE-1:0]       c_col,
   output logic [W_CHANNEL-1:0]    c_chn,
   output logic [W_IFM_BUF-1:0]    c_ifm_buf,
   output logic                    c_first_chn,
   output logic                    c_last_chn,
   output logic [W_FRAME_SIZE-1:0] o_beat_cnt,
   output logic                    o_busy,
   output logic                    o_frame_done
);

   seq_state_e             r_state;
   logic [W_SIZE-1:0]      r_q_w;
   logic [W_SIZE-1:0]      r_q_h;
   logic [W_CHANNEL-1:0]   r_q_ch;
   logic [W_DELAY-1:0]     r_q_drain;
   logic [W_DELAY-1:0]     r_drain_cnt;
   logic                   r_zero;
   logic                   r_row_end;
   logic                   r_frame_end;

   logic [W_SIZE-1:0]      w_row;
   logic [W_SIZE-1:0]      w_col;
   logic [W_CHANNEL-1:0]   w_chn;
   logic                   w_chn_wrap;
   logic                   w_col_wrap;
   logic                   w_row_wrap;
   logic                   w_emit;
   logic                   w_clr;

   // A beat goes out on row entry (readiness checked) or mid-row when not stalled.
   assign w_emit = ((r_state == SEQ_WAIT_ROW) && !r_zero && i_row_ready) ||
                   ((r_state == SEQ_RUN) && !r_row_end && !i_stall);
   assign w_clr  = (r_state == SEQ_IDLE) && i_start;

   conv_idx_counter #(
      .W_SIZE    (W_SIZE),
      .W_CHANNEL (W_CHANNEL)
   ) u_idx (
      .clk          (clk),
      .rstn         (rstn),
      .i_clr        (w_clr),
      .i_en         (w_emit),
      .i_last_col   (r_q_w - W_SIZE'(1)),
      .i_last_row   (r_q_h - W_SIZE'(1)),
      .i_last_chn   (r_q_ch - W_CHANNEL'(1)),
      .o_row        (w_row),
      .o_col        (w_col),
      .o_chn        (w_chn),
      .o_chn_wrap_c (w_chn_wrap),
      .o_col_wrap_c (w_col_wrap),
      .o_row_wrap_c (w_row_wrap)
   );

   // Sequencer FSM with shadow config, drain counter and registered beat outputs.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state         <= SEQ_IDLE;
         r_q_w           <= '0;
         r_q_h           <= '0;
         r_q_ch          <= '0;
         r_q_drain       <= '0;
         r_drain_cnt     <= '0;
         r_zero          <= 1'b0;
         r_row_end       <= 1'b0;
         r_frame_end     <= 1'b0;
         c_ctrl_data_run <= 1'b0;
         c_row           <= '0;
         c_col           <= '0;
         c_chn           <= '0;
         c_ifm_buf       <= '0;
         c_first_chn     <= 1'b0;
         c_last_chn      <= 1'b0;
         o_beat_cnt      <= '0;
         o_busy          <= 1'b0;
         o_frame_done    <= 1'b0;
      end else begin
         // Indices always track the next unissued beat; flags only qualify real beats.
         c_ctrl_data_run <= w_emit;
         c_row           <= w_row;
         c_col           <= w_col;
         c_chn           <= w_chn;
         c_ifm_buf       <= w_emit ? W_IFM_BUF'(w_row & W_SIZE'(IFM_BUF_CNT - 1)) : '0;
         c_first_chn     <= w_emit && (w_chn == '0);
         c_last_chn      <= w_emit && w_chn_wrap;
         r_row_end       <= w_emit && w_chn_wrap && w_col_wrap;
         r_frame_end     <= w_emit && w_chn_wrap && w_col_wrap && w_row_wrap;
         o_frame_done    <= 1'b0;
         if (w_emit && (o_beat_cnt != '1)) begin
            o_beat_cnt <= o_beat_cnt + W_FRAME_SIZE'(1);
         end

         case (r_state)
            SEQ_IDLE: begin
               if (i_start) begin
                  r_q_w      <= q_width;
                  r_q_h      <= q_height;
                  r_q_ch     <= q_channel;
                  r_q_drain  <= q_drain;
                  r_zero     <= (q_width == '0) || (q_height == '0) || (q_channel == '0);
                  o_beat_cnt <= '0;
                  o_busy     <= 1'b1;
                  r_state    <= SEQ_WAIT_ROW;
               end
            end
            SEQ_WAIT_ROW: begin
               if (r_zero) begin
                  o_frame_done <= 1'b1;
                  r_state      <= SEQ_DONE;
               end else if (i_row_ready) begin
                  r_state <= SEQ_RUN;
               end
            end
            SEQ_RUN: begin
               if (r_row_end) begin
                  if (r_frame_end) begin
                     r_drain_cnt <= r_q_drain;
                     r_state     <= SEQ_DRAIN;
                  end else begin
                     r_state <= SEQ_WAIT_ROW;
                  end
               end
            end
            SEQ_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  o_frame_done <= 1'b1;
                  r_state      <= SEQ_DONE;
               end else begin
                  r_drain_cnt <= r_drain_cnt - W_DELAY'(1);
               end
            end
            SEQ_DONE: begin
               o_busy  <= 1'b0;
               r_state <= SEQ_IDLE;
            end
            default: begin
               o_busy  <= 1'b0;
               r_state <= SEQ_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_data_seq.sv
// Directed testbench for conv_data_seq: per-scenario tasks with hand-computed expectations.
module tb_conv_data_seq;

   logic        clk;
   logic        rstn;
   logic        i_start;
   logic [7:0]  q_width;
   logic [7:0]  q_height;
   logic [5:0]  q_channel;
   logic [7:0]  q_drain;
   logic        i_row_ready;
   logic        i_stall;
   logic        c_ctrl_data_run;
   logic [7:0]  c_row;
   logic [7:0]  c_col;
   logic [5:0]  c_chn;
   logic [1:0]  c_ifm_buf;
   logic        c_first_chn;
   logic        c_last_chn;
   logic [15:0] o_beat_cnt;
   logic        o_busy;
   logic        o_frame_done;

   int total = 0;
   int bad   = 0;

   // Per-cycle stimulus patterns, cycle 0 is the start cycle of a scenario
   bit start_pat[64];
   bit stall_pat[64];
   bit ready_pat[64];
   bit rst_pat[64];
   int chg_cyc;

   // Per-cycle observations and the extracted beat list
   int ob_run[64];
   int ob_col[64];
   int ob_cnt[64];
   int ob_busy[64];
   int ob_data[64];
   int bq_cyc[$];
   int bq_row[$];
   int bq_col[$];
   int bq_chn[$];
   int bq_fl[$];
   int done_cyc;
   int done_n;

   conv_data_seq u_dut (
      .clk             (clk),
      .rstn            (rstn),
      .i_start         (i_start),
      .q_width         (q_width),
      .q_height        (q_height),
      .q_channel       (q_channel),
      .q_drain         (q_drain),
      .i_row_ready     (i_row_ready),
      .i_stall         (i_stall),
      .c_ctrl_data_run (c_ctrl_data_run),
      .c_row           (c_row),
      .c_col           (c_col),
      .c_chn           (c_chn),
      .c_ifm_buf       (c_ifm_buf),
      .c_first_chn     (c_first_chn),
      .c_last_chn      (c_last_chn),
      .o_beat_cnt      (o_beat_cnt),
      .o_busy          (o_busy),
      .o_frame_done    (o_frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_pats();
      for (int i = 0; i < 64; i++) begin
         start_pat[i] = 1'b0;
         stall_pat[i] = 1'b0;
         ready_pat[i] = 1'b1;
         rst_pat[i]   = 1'b0;
      end
      start_pat[0] = 1'b1;
      chg_cyc      = -1;
   endtask

   // Drive the patterns for n cycles, sampling outputs on the falling edge.
   task automatic run_cycles(input int n);
      bq_cyc.delete(); bq_row.delete(); bq_col.delete(); bq_chn.delete(); bq_fl.delete();
      done_cyc = -1;
      done_n   = 0;
      for (int c = 0; c < n; c++) begin
         i_start     = start_pat[c];
         i_stall     = stall_pat[c];
         i_row_ready = ready_pat[c];
         rstn        = rst_pat[c];
         if (c == chg_cyc) begin
            q_width  = 8'd7;
            q_height = 8'd7;
         end
         @(negedge clk);
         ob_run[c]  = int'(c_ctrl_data_run);
         ob_col[c]  = int'(c_col);
         ob_cnt[c]  = int'(o_beat_cnt);
         ob_busy[c] = int'(o_busy);
         ob_data[c] = int'(c_row) + int'(c_col) + int'(c_chn) + int'(c_ifm_buf) +
                      int'(c_first_chn) + int'(c_last_chn) + int'(o_beat_cnt);
         if (c_ctrl_data_run) begin
            bq_cyc.push_back(c);
            bq_row.push_back(int'(c_row));
            bq_col.push_back(int'(c_col));
            bq_chn.push_back(int'(c_chn));
            bq_fl.push_back(int'(c_ifm_buf) * 4 + int'(c_first_chn) * 2 + int'(c_last_chn));
         end
         if (o_frame_done) begin
            if (done_cyc < 0) done_cyc = c;
            done_n++;
         end
         @(posedge clk);
         #1;
      end
      i_start = 1'b0;
      i_stall = 1'b0;
      rstn    = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_row_ready = 1'b0;
      q_width = 8'd0; q_height = 8'd0; q_channel = 6'd0; q_drain = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if ({c_ctrl_data_run, o_busy, o_frame_done} !== 3'b000) begin
         bad++; $display("FAIL reset_ctrl: got %b exp 000", {c_ctrl_data_run, o_busy, o_frame_done});
      end
      total++;
      if ({c_row, c_col, c_chn} !== 22'd0) begin
         bad++; $display("FAIL reset_idx: got %0d/%0d/%0d exp 0/0/0", c_row, c_col, c_chn);
      end
      total++;
      if ({c_ifm_buf, c_first_chn, c_last_chn, o_beat_cnt} !== 20'd0) begin
         bad++; $display("FAIL reset_flags_cnt: got %b exp 0", {c_ifm_buf, c_first_chn, c_last_chn, o_beat_cnt});
      end
      @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if ({c_ctrl_data_run, o_busy, o_frame_done} !== 3'b000) begin
         bad++; $display("FAIL reset_idle: got %b exp 000", {c_ctrl_data_run, o_busy, o_frame_done});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      q_width = 8'd3; q_height = 8'd2; q_channel = 6'd2; q_drain = 8'd2;
      clear_pats();
      run_cycles(20);
      total++;
      if (bq_cyc.size() != 12) begin
         bad++; $display("FAIL basic_beats: got %0d exp 12", bq_cyc.size());
      end
      for (int b = 0; b < 12; b++) begin
         int r, j, ec, ecol, echn, efl;
         r = b / 6; j = b % 6;
         ec = 2 + r * 7 + j; ecol = j / 2; echn = j % 2;
         efl = r * 4 + ((echn == 0) ? 2 : 0) + ((echn == 1) ? 1 : 0);
         if (b < bq_cyc.size()) begin
            total++;
            if (bq_cyc[b] != ec || bq_row[b] != r || bq_col[b] != ecol || bq_chn[b] != echn) begin
               bad++;
               $display("FAIL basic_beat%0d: got cyc=%0d (%0d,%0d,%0d) exp cyc=%0d (%0d,%0d,%0d)",
                        b, bq_cyc[b], bq_row[b], bq_col[b], bq_chn[b], ec, r, ecol, echn);
            end
            total++;
            if (bq_fl[b] != efl) begin
               bad++; $display("FAIL basic_flags%0d: got %0d exp %0d", b, bq_fl[b], efl);
            end
         end
      end
      total++;
      if (done_cyc != 18 || done_n != 1) begin
         bad++; $display("FAIL basic_done: got cyc=%0d n=%0d exp cyc=18 n=1", done_cyc, done_n);
      end
      total++;
      if (ob_cnt[18] != 12) begin
         bad++; $display("FAIL basic_beat_cnt: got %0d exp 12", ob_cnt[18]);
      end
      total++;
      if (ob_busy[0] != 0 || ob_busy[1] != 1 || ob_busy[19] != 0) begin
         bad++; $display("FAIL basic_busy: got %0d%0d%0d exp 010", ob_busy[0], ob_busy[1], ob_busy[19]);
      end
   endtask

   task automatic test_stall();
      int ec[4] = '{2, 3, 7, 8};
      q_width = 8'd4; q_height = 8'd1; q_channel = 6'd1; q_drain = 8'd0;
      clear_pats();
      stall_pat[1] = 1'b1;
      stall_pat[3] = 1'b1; stall_pat[4] = 1'b1; stall_pat[5] = 1'b1;
      stall_pat[9] = 1'b1;
      run_cycles(12);
      total++;
      if (bq_cyc.size() != 4) begin
         bad++; $display("FAIL stall_beats: got %0d exp 4", bq_cyc.size());
      end
      for (int b = 0; b < 4; b++) begin
         if (b < bq_cyc.size()) begin
            total++;
            if (bq_cyc[b] != ec[b] || bq_row[b] != 0 || bq_col[b] != b || bq_chn[b] != 0) begin
               bad++;
               $display("FAIL stall_beat%0d: got cyc=%0d (%0d,%0d,%0d) exp cyc=%0d (0,%0d,0)",
                        b, bq_cyc[b], bq_row[b], bq_col[b], bq_chn[b], ec[b], b);
            end
         end
      end
      for (int c = 4; c <= 6; c++) begin
         total++;
         if (ob_run[c] != 0 || ob_col[c] != 2) begin
            bad++; $display("FAIL stall_hold%0d: got run=%0d col=%0d exp run=0 col=2", c, ob_run[c], ob_col[c]);
         end
      end
      total++;
      if (done_cyc != 10 || ob_cnt[10] != 4) begin
         bad++; $display("FAIL stall_done: got cyc=%0d cnt=%0d exp cyc=10 cnt=4", done_cyc, ob_cnt[10]);
      end
   endtask

   task automatic test_row_gate();
      int ec[6]   = '{2, 3, 10, 11, 13, 14};
      int erow[6] = '{0, 0, 1, 1, 2, 2};
      q_width = 8'd2; q_height = 8'd3; q_channel = 6'd1; q_drain = 8'd1;
      clear_pats();
      for (int c = 4; c <= 8; c++) ready_pat[c] = 1'b0;
      ready_pat[10] = 1'b0;
      run_cycles(19);
      total++;
      if (bq_cyc.size() != 6) begin
         bad++; $display("FAIL gate_beats: got %0d exp 6", bq_cyc.size());
      end
      for (int b = 0; b < 6; b++) begin
         if (b < bq_cyc.size()) begin
            total++;
            if (bq_cyc[b] != ec[b] || bq_row[b] != erow[b] || bq_col[b] != b % 2) begin
               bad++;
               $display("FAIL gate_beat%0d: got cyc=%0d (%0d,%0d) exp cyc=%0d (%0d,%0d)",
                        b, bq_cyc[b], bq_row[b], bq_col[b], ec[b], erow[b], b % 2);
            end
            total++;
            if (bq_fl[b] != erow[b] * 4 + 3) begin
               bad++; $display("FAIL gate_ifm%0d: got %0d exp %0d", b, bq_fl[b], erow[b] * 4 + 3);
            end
         end
      end
      total++;
      if (done_cyc != 17) begin
         bad++; $display("FAIL gate_done: got %0d exp 17", done_cyc);
      end
   endtask

   task automatic test_zero();
      q_width = 8'd3; q_height = 8'd2; q_channel = 6'd0; q_drain = 8'd3;
      clear_pats();
      run_cycles(5);
      total++;
      if (done_cyc != 2 || done_n != 1) begin
         bad++; $display("FAIL zero_done: got cyc=%0d n=%0d exp cyc=2 n=1", done_cyc, done_n);
      end
      total++;
      if (bq_cyc.size() != 0) begin
         bad++; $display("FAIL zero_beats: got %0d exp 0", bq_cyc.size());
      end
      total++;
      if (ob_cnt[2] != 0) begin
         bad++; $display("FAIL zero_beat_cnt: got %0d exp 0", ob_cnt[2]);
      end
      total++;
      if (ob_busy[2] != 1 || ob_busy[3] != 0) begin
         bad++; $display("FAIL zero_busy: got %0d%0d exp 10", ob_busy[2], ob_busy[3]);
      end
   endtask

   task automatic test_flags();
      q_width = 8'd1; q_height = 8'd6; q_channel = 6'd3; q_drain = 8'd0;
      clear_pats();
      run_cycles(28);
      total++;
      if (bq_cyc.size() != 18) begin
         bad++; $display("FAIL flags_beats: got %0d exp 18", bq_cyc.size());
      end
      for (int b = 0; b < 18; b++) begin
         int r, k, ec, efl;
         r = b / 3; k = b % 3;
         ec  = 2 + 4 * r + k;
         efl = (r % 4) * 4 + ((k == 0) ? 2 : 0) + ((k == 2) ? 1 : 0);
         if (b < bq_cyc.size()) begin
            total++;
            if (bq_cyc[b] != ec || bq_row[b] != r || bq_col[b] != 0 || bq_chn[b] != k) begin
               bad++;
               $display("FAIL flags_beat%0d: got cyc=%0d (%0d,%0d,%0d) exp cyc=%0d (%0d,0,%0d)",
                        b, bq_cyc[b], bq_row[b], bq_col[b], bq_chn[b], ec, r, k);
            end
            total++;
            if (bq_fl[b] != efl) begin
               bad++; $display("FAIL flags_fl%0d: got %0d exp %0d", b, bq_fl[b], efl);
            end
         end
      end
      total++;
      if (done_cyc != 26 || ob_cnt[26] != 18) begin
         bad++; $display("FAIL flags_done: got cyc=%0d cnt=%0d exp cyc=26 cnt=18", done_cyc, ob_cnt[26]);
      end
   endtask

   task automatic test_restart_ignored();
      q_width = 8'd3; q_height = 8'd2; q_channel = 6'd2; q_drain = 8'd2;
      clear_pats();
      start_pat[5] = 1'b1;
      chg_cyc      = 4;
      run_cycles(20);
      total++;
      if (bq_cyc.size() != 12) begin
         bad++; $display("FAIL restart_beats: got %0d exp 12", bq_cyc.size());
      end
      if (bq_cyc.size() == 12) begin
         total++;
         if (bq_cyc[11] != 14 || bq_row[11] != 1 || bq_col[11] != 2 || bq_chn[11] != 1) begin
            bad++;
            $display("FAIL restart_last: got cyc=%0d (%0d,%0d,%0d) exp cyc=14 (1,2,1)",
                     bq_cyc[11], bq_row[11], bq_col[11], bq_chn[11]);
         end
      end
      total++;
      if (done_cyc != 18 || done_n != 1 || ob_cnt[18] != 12) begin
         bad++; $display("FAIL restart_done: got cyc=%0d n=%0d cnt=%0d exp 18/1/12", done_cyc, done_n, ob_cnt[18]);
      end
   endtask

   task automatic test_reset_mid();
      q_width = 8'd3; q_height = 8'd2; q_channel = 6'd2; q_drain = 8'd2;
      clear_pats();
      rst_pat[10] = 1'b1;
      run_cycles(30);
      total++;
      if (ob_run[10] != 1) begin
         bad++; $display("FAIL rstmid_pre: got run=%0d exp 1", ob_run[10]);
      end
      total++;
      if (ob_run[11] != 0 || ob_busy[11] != 0) begin
         bad++; $display("FAIL rstmid_ctrl: got run=%0d busy=%0d exp 0/0", ob_run[11], ob_busy[11]);
      end
      total++;
      if (ob_data[11] != 0) begin
         bad++; $display("FAIL rstmid_data: got sum=%0d exp 0", ob_data[11]);
      end
      total++;
      if (bq_cyc.size() != 8 || done_n != 0) begin
         bad++; $display("FAIL rstmid_after: got beats=%0d done=%0d exp 8/0", bq_cyc.size(), done_n);
      end
      total++;
      if (ob_busy[29] != 0) begin
         bad++; $display("FAIL rstmid_idle: got busy=%0d exp 0", ob_busy[29]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_row_gate();
      test_zero();
      test_flags();
      test_restart_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
